bcd_serial_digit_mul: RTL and testbench
=======================================

// Module: bcd_serial_digit_mul
// PURPOSE
//  Multiplies an unsigned NUM_DIGITS-digit packed-BCD number by one BCD digit (0..9).
//  Digit-serial: one multiplicand digit per clock, LSD first, with a running decimal carry.
//  Generalises the fixed single-digit x5 BCD scaler to any width and any digit multiplier.
//  Sits between BCD entry/accumulator logic and BCD display/adder stages.
// PARAMETERS
//  NUM_DIGITS  4  multiplicand digit count (>=1); product is NUM_DIGITS+1 digits
// PORTS
//  i_clk           in   1                clock, rising edge
//  i_rstn          in   1                async active-low reset
//  i_start         in   1                request; accepted only when o_ready=1
//  i_multiplicand  in   4*NUM_DIGITS     packed BCD, digit 0 in [3:0]
//  i_multiplier    in   4                BCD digit 0..9
//  o_ready         out  1                1 in IDLE only
//  o_valid         out  1                1-cycle pulse: o_product/o_error valid
//  o_product       out  4*(NUM_DIGITS+1) packed BCD result, held until next acceptance
//  o_error         out  1                1 if accepted operands contained a nibble >9
// BEHAVIOUR
//  Reset (async, i_rstn=0): state=IDLE, o_ready=1, o_valid=0, o_product=0, o_error=0,
//   digit index=0, carry=0. Reset mid-operation aborts; no o_valid is produced.
//  FSM IDLE -> CALC -> DONE -> IDLE.
//  IDLE: edge with i_start=1 latches both operands, clears o_product/o_error, carry=0,
//   idx=0. If any latched nibble >9: o_error=1, o_product=0, go DONE (skip CALC).
//   Otherwise go CALC. i_start=0: stay.
//  CALC: each edge: p = mcand[idx]*mult + carry (0..89, 7 bits); product digit idx =
//   p mod 10; carry = p div 10 (0..8). After idx=NUM_DIGITS-1: top product digit =
//   final carry, go DONE; else idx++. Exactly NUM_DIGITS edges in CALC.
//  DONE: o_valid=1 for exactly one cycle, o_ready=0; next edge -> IDLE.
//  Latency: acceptance edge to o_valid high = NUM_DIGITS+1 edges (error: 1 edge).
//  o_ready=0 in CALC/DONE; i_start and operand changes ignored while busy.
//  Back-to-back: i_start held high re-accepts on the first IDLE edge after DONE.
//  Divide-by-10 done with compare/subtract or constant logic; no '/' or '%' operators.
//  Every o_product nibble is always a legal BCD digit 0..9.
// TESTING
//  N=4: 9999 x 9 -> o_product=89991, o_error=0, o_valid 5 edges after accept.
//  N=4: 1234 x 5 -> 06170; 0000 x 7 -> 00000; 4321 x 0 -> 00000; 0001 x 1 -> 00001.
//  N=4: 12A4 x 3 -> o_error=1, o_product=0, o_valid 1 edge after accept;
//   also 1234 x 4'hC -> o_error=1.
//  Pulse i_start during CALC with other operands -> ignored; first result unchanged.
//  Drop i_rstn mid-CALC -> outputs reset immediately, no o_valid; then 0042 x 6 -> 00252.
//  N=1 exhaustive: all a,b in 0..9 -> product equals a*b in BCD; also every
//   x5 case matches the fixed x5 scaler (e.g. 7 x 5 -> 35).

Source files
------------

// File: rtl/bcd_serial_digit_mul.sv
// ----------------------------------------------------------------------------
// bcd_serial_digit_mul
//
// Purpose:
//   Multiplies an unsigned NUM_DIGITS-digit packed-BCD number by a single BCD
//   digit (0..9). The multiplicand is processed one digit per clock, least
//   significant digit first, with a running decimal carry (0..8). The result
//   has NUM_DIGITS+1 digits, and the top digit is the final carry.
//   Operands containing a nibble above 9 are rejected. In that case the block
//   reports o_error with a zero product after a single cycle.
//
// Parameters:
//   NUM_DIGITS      multiplicand digit count (>=1)
//
// Ports:
//   i_clk           clock, rising edge
//   i_rstn          asynchronous active-low reset
//   i_start         request, accepted only while o_ready=1
//   i_multiplicand  packed BCD multiplicand, digit 0 in [3:0]
//   i_multiplier    BCD multiplier digit 0..9
//   o_ready         high only while idle
//   o_valid         one-cycle pulse: o_product / o_error are valid
//   o_product       packed BCD product, held until the next acceptance
//   o_error         operands of the accepted request contained a nibble >9
// ----------------------------------------------------------------------------
module bcd_serial_digit_mul #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_start,
    input  logic [4*NUM_DIGITS-1:0]       i_multiplicand,
    input  logic [3:0]                    i_multiplier,
    output logic                          o_ready,
    output logic                          o_valid,
    output logic [4*(NUM_DIGITS+1)-1:0]   o_product,
    output logic                          o_error
);

    // The digit index needs at least one bit, even when NUM_DIGITS is 1.
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              r_state;
    logic [4*NUM_DIGITS-1:0] r_mcand;
    logic [3:0]              r_mult;
    logic [IDX_W-1:0]        r_idx;
    logic [3:0]              r_carry;
    logic                    r_error;
    logic [3:0]              r_top_digit;

    logic                    w_accept;
    logic [NUM_DIGITS-1:0]   w_nib_bad;
    logic                    w_any_bad;
    logic                    w_calc;
    logic                    w_last;
    logic [3:0]              w_cur_digit;
    logic [6:0]              w_prod;
    logic [7:0]              w_ge;
    logic [3:0]              w_quot;
    logic [3:0]              w_rem;
    logic [3:0]              w_q10_lo;

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_calc   = (r_state == S_CALC);
    assign w_last   = (r_idx == LAST_IDX);

    // ------------------------------------------------------------------
    // Operand legality check. This runs on the incoming operands, so the
    // decision is made on the same edge that latches them.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_chk
            assign w_nib_bad[gi] = (i_multiplicand[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign w_any_bad = (|w_nib_bad) || (i_multiplier > 4'd9);

    // ------------------------------------------------------------------
    // Select the multiplicand digit addressed by the running index.
    // This is written as a compare-select mux, so index values at or
    // above NUM_DIGITS (possible when NUM_DIGITS is not a power of two)
    // select 0 instead of indexing out of range.
    // ------------------------------------------------------------------
    always_comb begin
        w_cur_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_cur_digit = r_mcand[4*i +: 4];
            end
        end
    end

    // The partial product is digit*mult + carry, which is at most 9*9+8 = 89.
    assign w_prod = 7'({3'b000, w_cur_digit} * {3'b000, r_mult}) + {3'b000, r_carry};

    // ------------------------------------------------------------------
    // Divide by 10 without a divider. Each threshold 10,20,...,80 has its
    // own comparator. The comparator outputs form a thermometer code, so
    // their population count is the quotient.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 1; gi <= 8; gi++) begin : g_div
            assign w_ge[gi-1] = (w_prod >= 7'(gi * 10));
        end
    endgenerate

    always_comb begin
        w_quot = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_quot = w_quot + {3'b000, w_ge[i]};
        end
    end

    // The remainder is below 10, so it fits in 4 bits. Only the low 4 bits
    // of quot*10 = (quot<<3) + (quot<<1) matter, and modulo-16 subtraction
    // gives the exact remainder.
    assign w_q10_lo = {w_quot[0], 3'b000} + {w_quot[2:0], 1'b0};
    assign w_rem    = w_prod[3:0] - w_q10_lo;

    // ------------------------------------------------------------------
    // Control path.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_mult  <= 4'd0;
            r_idx   <= '0;
            r_carry <= 4'd0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mcand <= i_multiplicand;
                        r_mult  <= i_multiplier;
                        r_idx   <= '0;
                        r_carry <= 4'd0;
                        if (w_any_bad) begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_error <= 1'b0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_carry <= w_quot;
                    if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Product digit registers. Each register is cleared on acceptance and
    // loaded with the remainder on the CALC cycle that addresses it. As a
    // result, every nibble is always a legal digit.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] r_digit;
            logic       w_we;

            assign w_we = w_calc && (r_idx == IDX_W'(gi));

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_digit <= 4'd0;
                end else if (w_accept) begin
                    r_digit <= 4'd0;
                end else if (w_we) begin
                    r_digit <= w_rem;
                end
            end

            assign o_product[4*gi +: 4] = r_digit;
        end
    endgenerate

    // The top digit takes the final carry out of the last CALC step.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_top_digit <= 4'd0;
        end else if (w_accept) begin
            r_top_digit <= 4'd0;
        end else if (w_calc && w_last) begin
            r_top_digit <= w_quot;
        end
    end

    assign o_product[4*NUM_DIGITS +: 4] = r_top_digit;

    assign o_ready = (r_state == S_IDLE);
    assign o_valid = (r_state == S_DONE);
    assign o_error = r_error;

endmodule

// File: tb/tb_bcd_serial_digit_mul.sv
// ----------------------------------------------------------------------------
// tb_bcd_serial_digit_mul
//
// Testbench with two instances: a 4-digit multiplier and a 1-digit
// multiplier. Driver tasks push the expected product, error flag and
// latency into a queue when they issue a request. An independent monitor
// per instance pops an entry and compares it each time o_valid is seen.
// ----------------------------------------------------------------------------
module tb_bcd_serial_digit_mul;

    typedef struct {
        logic [19:0] prod;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0;
    logic [15:0] mc4 = '0;
    logic [3:0]  ml4 = '0;
    logic        rdy4, val4, err4;
    logic [19:0] prod4;

    logic        start1 = 1'b0;
    logic [3:0]  mc1 = '0;
    logic [3:0]  ml1 = '0;
    logic        rdy1, val1, err1;
    logic [7:0]  prod1;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    bcd_serial_digit_mul #(.NUM_DIGITS(4)) u_dut4 (
        .i_clk          (clk),
        .i_rstn         (rst_n),
        .i_start        (start4),
        .i_multiplicand (mc4),
        .i_multiplier   (ml4),
        .o_ready        (rdy4),
        .o_valid        (val4),
        .o_product      (prod4),
        .o_error        (err4)
    );

    bcd_serial_digit_mul #(.NUM_DIGITS(1)) u_dut1 (
        .i_clk          (clk),
        .i_rstn         (rst_n),
        .i_start        (start1),
        .i_multiplicand (mc1),
        .i_multiplier   (ml1),
        .o_ready        (rdy1),
        .o_valid        (val1),
        .o_product      (prod1),
        .o_error        (err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int   edge4 = 0;
    int   acc4  = 0;
    exp_t e4;
    always @(posedge clk) begin
        edge4++;
        if (rst_n && rdy4 && start4) acc4 = edge4;
        #1;
        if (rst_n && val4) begin
            if (q4.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid4: got product %h err %b, expected no result", prod4, err4);
            end else begin
                e4 = q4.pop_front();
                $display("tx4 product=%h err=%b latency=%0d (exp %h/%b/%0d)",
                         prod4, err4, edge4 - acc4 + 1, e4.prod, e4.err, e4.lat);
                check("product4", {12'd0, prod4}, {12'd0, e4.prod});
                check("error4", {31'd0, err4}, {31'd0, e4.err});
                check("latency4", edge4 - acc4 + 1, e4.lat);
            end
        end
    end

    int   edge1 = 0;
    int   acc1  = 0;
    exp_t e1;
    always @(posedge clk) begin
        edge1++;
        if (rst_n && rdy1 && start1) acc1 = edge1;
        #1;
        if (rst_n && val1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid1: got product %h err %b, expected no result", prod1, err1);
            end else begin
                e1 = q1.pop_front();
                $display("tx1 product=%h err=%b latency=%0d (exp %h/%b/%0d)",
                         prod1, err1, edge1 - acc1 + 1, e1.prod[7:0], e1.err, e1.lat);
                check("product1", {24'd0, prod1}, {12'd0, e1.prod});
                check("error1", {31'd0, err1}, {31'd0, e1.err});
                check("latency1", edge1 - acc1 + 1, e1.lat);
            end
        end
    end

    // ---------------- drivers ----------------
    // Each driver is entered #1 after a rising edge and returns #1 after
    // the acceptance edge.
    task automatic issue4(input logic [15:0] a, input logic [3:0] b,
                          input logic [19:0] p, input logic e, input bit push);
        int cnt = 0;
        while (!rdy4 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!rdy4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready4_timeout: got ready 0, expected 1 within 100 cycles");
            return;
        end
        mc4 = a;
        ml4 = b;
        start4 = 1'b1;
        if (push) q4.push_back('{p, e, (e ? 1 : 5)});
        @(posedge clk); #1;
        start4 = 1'b0;
    endtask

    task automatic issue1(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] p, input logic e);
        int cnt = 0;
        while (!rdy1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!rdy1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready1_timeout: got ready 0, expected 1 within 100 cycles");
            return;
        end
        mc1 = a;
        ml1 = b;
        start1 = 1'b1;
        q1.push_back('{{12'd0, p}, e, (e ? 1 : 2)});
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         cnt;
        int         prod_int;
        logic [7:0] exp1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready4",   {31'd0, rdy4}, 32'd1);
        check("rst_valid4",   {31'd0, val4}, 32'd0);
        check("rst_product4", {12'd0, prod4}, 32'd0);
        check("rst_error4",   {31'd0, err4}, 32'd0);
        check("rst_ready1",   {31'd0, rdy1}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed 4-digit vectors
        issue4(16'h9999, 4'd9, 20'h89991, 1'b0, 1'b1);
        issue4(16'h1234, 4'd5, 20'h06170, 1'b0, 1'b1);
        // A start pulse during CALC, with different operands, must be ignored.
        @(posedge clk); #1;
        mc4 = 16'h9999;
        ml4 = 4'd9;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        issue4(16'h0000, 4'd7, 20'h00000, 1'b0, 1'b1);
        issue4(16'h4321, 4'd0, 20'h00000, 1'b0, 1'b1);
        issue4(16'h0001, 4'd1, 20'h00001, 1'b0, 1'b1);
        issue4(16'h12A4, 4'd3, 20'h00000, 1'b1, 1'b1);
        issue4(16'h1234, 4'hC, 20'h00000, 1'b1, 1'b1);
        issue4(16'h5678, 4'd8, 20'h45424, 1'b0, 1'b1);

        // Reset during CALC: the result is aborted and no o_valid follows.
        issue4(16'h1234, 4'd3, 20'h03702, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready4",   {31'd0, rdy4}, 32'd1);
        check("midrst_valid4",   {31'd0, val4}, 32'd0);
        check("midrst_product4", {12'd0, prod4}, 32'd0);
        check("midrst_error4",   {31'd0, err4}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        issue4(16'h0042, 4'd6, 20'h00252, 1'b0, 1'b1);

        // 1-digit exhaustive. For the x5 cases the expected value comes from
        // the fixed x5 scaler form: tens = a>>1, units = 5 if a is odd, else 0.
        for (int a = 0; a < 10; a++) begin
            for (int b = 0; b < 10; b++) begin
                if (b == 5) begin
                    exp1 = {4'(a >> 1), ((a % 2) == 1) ? 4'd5 : 4'd0};
                end else begin
                    prod_int = a * b;
                    exp1 = {4'(prod_int / 10), 4'(prod_int % 10)};
                end
                issue1(4'(a), 4'(b), exp1, 1'b0);
            end
        end
        issue1(4'd7, 4'd5, 8'h35, 1'b0);
        issue1(4'hB, 4'd2, 8'h00, 1'b1);

        // Drain the scoreboards, then watch briefly for stray results.
        cnt = 0;
        while ((q4.size() != 0 || q1.size() != 0) && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (q4.size() != 0 || q1.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending results, expected 0/0", q4.size(), q1.size());
        end
        repeat (10) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
